// File: rtl/frame_packer_n_m.sv
// frame_packer_n_m: packs a valid/ready stream of n-bit words into an
// (m+1)-slot frame, held with a frame-valid/ack handshake until taken.
// Optional feature macro: FRAME_PACKER_FLUSH_EN adds flush_i, which closes a
// partial frame early and pads the remaining slots with `fill`.

// One frame slot: resets to fill, loads only when its write enable is set.
module frame_packer_n_m_slot #(
    parameter int unsigned  n    = 4,
    parameter logic [n-1:0] fill = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         we_i,
    input  logic [n-1:0] d_i,
    output logic [n-1:0] q_o
);
    logic [n-1:0] slot_q;

    // slot storage, held unless explicitly written
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)    slot_q <= fill;
        else if (we_i) slot_q <= d_i;
    end

    assign q_o = slot_q;
endmodule

module frame_packer_n_m #(
    parameter int unsigned  n    = 4,
    parameter int unsigned  m    = 15,
    parameter logic [n-1:0] fill = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [n-1:0]            data_i,
    input  logic                    valid_i,
    output logic                    ready_o,
`ifdef FRAME_PACKER_FLUSH_EN
    input  logic                    flush_i,
`endif
    output logic [n-1:0]            frame_o [0:m],
    output logic                    frame_valid_o,
    input  logic                    frame_ack_i,
    output logic [$clog2(m+2)-1:0]  count_o
);
    localparam int unsigned IW = (m > 0) ? $clog2(m + 1) : 1;
    localparam int unsigned CW = $clog2(m + 2);

    typedef enum logic {FILL, HOLD} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            xfer, close;
    logic            slot_we [0:m];
    logic [n-1:0]    slot_wd [0:m];

    assign ready_o       = (state_q == FILL);
    assign frame_valid_o = (state_q == HOLD);
    assign count_o       = cnt_q;
    assign xfer          = valid_i && (state_q == FILL);

`ifdef FRAME_PACKER_FLUSH_EN
    // flush only closes a frame that will hold at least one real word
    assign close = flush_i && (state_q == FILL) && (xfer || (cnt_q != '0));
`else
    assign close = 1'b0;
`endif

    // per-slot write: incoming word at idx, pad slots past it on an early close
    always_comb begin
        for (int i = 0; i <= m; i++) begin
            slot_we[i] = 1'b0;
            slot_wd[i] = fill;
            if (xfer && (IW'(i) == idx_q)) begin
                slot_we[i] = 1'b1;
                slot_wd[i] = data_i;
            end else if (close && (IW'(i) >= idx_q)) begin
                slot_we[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g <= m; g++) begin : g_slot
        frame_packer_n_m_slot #(.n(n), .fill(fill)) u_slot (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .we_i  (slot_we[g]),
            .d_i   (slot_wd[g]),
            .q_o   (frame_o[g])
        );
    end

    // FSM next state: fill slots in order, hold the finished frame until ack
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            FILL: begin
                if (xfer) begin
                    idx_d = idx_q + IW'(1);
                    cnt_d = cnt_q + CW'(1);
                end
                // idx wraps on completion so it never reaches m+1
                if ((xfer && (idx_q == IW'(m))) || close) begin
                    state_d = HOLD;
                    idx_d   = '0;
                end
            end
            HOLD: begin
                if (frame_ack_i) begin
                    state_d = FILL;
                    cnt_d   = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // FSM state, write index and word count registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= FILL;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_frame_packer_n_m.sv
// Bench for frame_packer_n_m (n=4, m=3, fill=A): directed literal checks plus
// randomized traffic against a queue-based frame model.
module tb_frame_packer_n_m;
    localparam int N = 4;
    localparam int M = 3;
    localparam logic [N-1:0] FV = 4'hA;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [N-1:0] data_i;
    logic         valid_i;
    logic         ready_o;
    logic         flush_i;
    logic [N-1:0] frame_o [0:M];
    logic         frame_valid_o;
    logic         frame_ack_i;
    logic [2:0]   count_o;

    always #5 clk_i = ~clk_i;

    frame_packer_n_m #(.n(N), .m(M), .fill(FV)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .data_i        (data_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
`ifdef FRAME_PACKER_FLUSH_EN
        .flush_i       (flush_i),
`endif
        .frame_o       (frame_o),
        .frame_valid_o (frame_valid_o),
        .frame_ack_i   (frame_ack_i),
        .count_o       (count_o)
    );

    int errors = 0;
    int checks = 0;
    bit cmp_en = 0;

    // model: words of the frame being collected, and the frame on offer
    logic [N-1:0] cur [$];
    logic [N-1:0] held_frame [0:M];
    int           held_cnt;
    bit           held;
    logic [N-1:0] exp4 [0:M];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        cur.delete();
        held     = 0;
        held_cnt = 0;
    endtask

    // one clock edge of the frame rules, applied to the inputs as sampled
    task automatic mdl_step();
        bit fl;
        fl = 0;
`ifdef FRAME_PACKER_FLUSH_EN
        fl = flush_i;
`endif
        if (!rst_i) mdl_reset();
        else if (held) begin
            if (frame_ack_i) held = 0;
        end else begin
            if (valid_i) cur.push_back(data_i);
            if (cur.size() == M + 1 || (fl && cur.size() > 0)) begin
                for (int i = 0; i <= M; i++)
                    held_frame[i] = (i < cur.size()) ? cur[i] : FV;
                held_cnt = cur.size();
                held     = 1;
                cur.delete();
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        mdl_step();
        #1;
    endtask

    task automatic set_rst(input logic v);
        rst_i = v;
        if (!v) mdl_reset();
    endtask

    // every cycle: handshake/count against the model, frame when it is valid
    always @(negedge clk_i) begin
        if (cmp_en) begin
            chk("ready", ready_o, !held);
            chk("frame_valid", frame_valid_o, held);
            chk("count", count_o, held ? held_cnt : cur.size());
            if (held)
                for (int i = 0; i <= M; i++)
                    chk($sformatf("frame_slot%0d", i), frame_o[i], held_frame[i]);
        end
    end

    initial begin
        rst_i = 1'b0; valid_i = 0; data_i = '0; frame_ack_i = 0; flush_i = 0;
        mdl_reset();
        #12;
        for (int i = 0; i <= M; i++) chk("rst_slot", frame_o[i], FV);
        chk("rst_valid", frame_valid_o, 0);
        chk("rst_ready", ready_o, 1);
        chk("rst_count", count_o, 0);
        cmp_en = 1;
        tick();
        set_rst(1);

        // fill one frame back to back
        for (int w = 1; w <= 4; w++) begin
            data_i = N'(w); valid_i = 1;
            tick();
        end
        valid_i = 0;
        for (int i = 0; i <= M; i++) chk("full_frame", frame_o[i], i + 1);
        chk("full_valid", frame_valid_o, 1);
        chk("full_ready", ready_o, 0);
        chk("full_count", count_o, 4);

        // held frame ignores valid traffic
        data_i = 4'h9; valid_i = 1;
        repeat (5) tick();
        valid_i = 0;
        for (int i = 0; i <= M; i++) chk("hold_frame", frame_o[i], i + 1);
        chk("hold_valid", frame_valid_o, 1);

        frame_ack_i = 1; tick(); frame_ack_i = 0;
        chk("ack_valid", frame_valid_o, 0);
        chk("ack_ready", ready_o, 1);
        chk("ack_count", count_o, 0);

        data_i = 4'h5; valid_i = 1; tick(); valid_i = 0;
        chk("w5_slot0", frame_o[0], 5);
        chk("w5_count", count_o, 1);
        data_i = 4'h7; valid_i = 1; tick();
        data_i = 4'h8; tick(); valid_i = 0;
        chk("w78_count", count_o, 3);

        // asynchronous reset mid-frame
        #2; set_rst(0); #1;
        for (int i = 0; i <= M; i++) chk("midrst_slot", frame_o[i], FV);
        chk("midrst_count", count_o, 0);
        chk("midrst_valid", frame_valid_o, 0);
        tick(); set_rst(1);
        data_i = 4'h3; valid_i = 1; tick(); valid_i = 0;
        chk("postrst_slot0", frame_o[0], 3);
        chk("postrst_slot1", frame_o[1], FV);
        chk("postrst_count", count_o, 1);

`ifdef FRAME_PACKER_FLUSH_EN
        set_rst(0); tick(); set_rst(1);
        data_i = 4'h5; valid_i = 1; tick();
        data_i = 4'h6; flush_i = 1; tick();
        valid_i = 0; flush_i = 0;
        exp4[0] = 4'h5; exp4[1] = 4'h6; exp4[2] = FV; exp4[3] = FV;
        for (int i = 0; i <= M; i++) chk("flush_frame", frame_o[i], exp4[i]);
        chk("flush_count", count_o, 2);
        chk("flush_valid", frame_valid_o, 1);
        frame_ack_i = 1; tick(); frame_ack_i = 0;
        flush_i = 1; tick(); flush_i = 0;
        chk("flush0_valid", frame_valid_o, 0);
        chk("flush0_ready", ready_o, 1);
        chk("flush0_count", count_o, 0);
`endif

        // randomized traffic, occasional acks in FILL, flushes and resets
        repeat (3000) begin
            valid_i     = ($urandom_range(0, 9) < 7);
            data_i      = N'($urandom);
            frame_ack_i = ($urandom_range(0, 3) == 0);
            flush_i     = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 299) == 0) set_rst(0);
            else if (!rst_i) set_rst(1);
            tick();
        end
        valid_i = 0; frame_ack_i = 0; flush_i = 0; set_rst(1);
        tick();
        cmp_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/frame_packer_n_m.md
# frame_packer_n_m

Collects a stream of n-bit words, arriving over a valid/ready handshake, into a frame of m+1 words. It presents the completed frame as an unpacked array `frame_o[0:m]` with a frame-valid/ack handshake. The block sits directly upstream of the team's n×(m+1) register bank (dff_n_m_val family) and drives that bank's array input. `frame_o` holds stable from frame completion until the consumer acknowledges.

## Interface
Parameters:
- n, 4, word width in bits
- m, 15, index of the last slot; the frame holds m+1 words
- fill, 0, reset value of every slot and the pad value used by flush

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- data_i  in  n  input word
- valid_i  in  1  data_i valid
- ready_o  out  1  block accepts a word this cycle
- flush_i  in  1  close a partial frame early (present only with FRAME_PACKER_FLUSH_EN)
- frame_o  out  n × [0:m]  unpacked array of frame words; slot 0 holds the first word received
- frame_valid_o  out  1  frame_o holds a complete frame
- frame_ack_i  in  1  consumer has taken the frame
- count_o  out  $clog2(m+2)  number of real words written in the current frame, 0..m+1

## Operation
- State machine with two states: FILL and HOLD. State resets to FILL.
- Reset values (asynchronous, active-low):
  - every frame_o slot = fill
  - write index = 0
  - count_o = 0
  - frame_valid_o = 0
  - state = FILL, so ready_o = 1
  - handshakes are ignored while rst_i is low.
- ready_o is combinational: ready_o = (state == FILL). It has no dependence on valid_i.
- FILL:
  - A transfer occurs when valid_i && ready_o at a rising clk_i edge.
  - On a transfer, slot[idx] <= data_i, idx <= idx+1, and count_o <= count_o+1.
  - When a transfer writes idx == m, the frame is complete: state <= HOLD, frame_valid_o <= 1, and idx wraps to 0. Because idx wraps, it never reaches m+1.
- HOLD:
  - ready_o = 0 and frame_o is frozen. valid_i is ignored; no word is lost because the producer sees ready_o low.
  - On frame_ack_i = 1: state <= FILL, frame_valid_o <= 0, count_o <= 0.
  - Slots are not cleared on ack. They are overwritten in order by the next frame. frame_o is defined only while frame_valid_o = 1.
- frame_ack_i in FILL is ignored.
- Reset mid-frame discards the partial frame. All slots return to fill and the block restarts at slot 0.

## Timing
- frame_valid_o rises on the clock edge that captures word m. Latency from the last transfer to valid is 0 cycles after that edge; the frame is usable in the following cycle.
- Ack is registered. frame_valid_o and ready_o change on the edge that samples frame_ack_i = 1.
- The first word of the next frame can transfer one cycle after the ack edge. This gives one mandatory bubble per frame.
- Maximum throughput is m+1 words per m+2 cycles plus consumer ack latency.
- frame_o slots change only on their own write edge, or on the flush edge with FRAME_PACKER_FLUSH_EN.

## Configuration
- Macro: FRAME_PACKER_FLUSH_EN.
- When defined, the flush_i port exists and is honoured only in FILL:
  - Flush with count_o > 0: slots idx..m <= fill, state <= HOLD, frame_valid_o <= 1, idx <= 0. count_o keeps the number of real words.
  - Flush and transfer in the same cycle: data_i goes to slot idx first, then slots idx+1..m are padded. count_o increments. If idx == m, this is a normal completion.
  - Flush with count_o == 0 and no transfer: ignored.
  - flush_i in HOLD is ignored.
- When undefined, the port is absent and frames complete only after m+1 transfers.

## Test plan
- Reset with n=4, m=3, fill=4'hA -> all four slots = A, frame_valid_o = 0, ready_o = 1, count_o = 0.
- Stream 1,2,3,4 on back-to-back cycles -> the edge after word 4 gives frame_o = {1,2,3,4}, frame_valid_o = 1, ready_o = 0, count_o = 4.
- In HOLD, drive valid_i with 9 for 5 cycles and no ack -> frame_o unchanged at {1,2,3,4}. Then pulse ack -> frame_valid_o = 0, ready_o = 1. Word 5 then goes to slot 0.
- Drop rst_i after words 7 and 8 -> slots = A immediately, count_o = 0. The next word lands in slot 0.
- With FRAME_PACKER_FLUSH_EN: send 5, then flush_i together with valid_i carrying 6 -> frame_o = {5,6,A,A}, count_o = 2, frame_valid_o = 1.
- With FRAME_PACKER_FLUSH_EN: flush_i at count_o = 0 with no valid_i -> no state change, frame_valid_o stays 0.
